mod_counter_ctrl: RTL and testbench

Sequencing controller for the modulo-N counter datapath in the ED13 counter family. It accepts a configuration (terminal count, run mode) through a valid/ready handshake and runs the count under start/hold/stop commands. It produces the count value, a terminal-count strobe and status flags. The block is the front-end that system logic uses to drive a programmable divide-by-N counter, instead of the fixed mod-6 chain.

---
 rtl/counter_pkg.sv | 14 +
 rtl/mod_n_core.sv | 27 ++
 rtl/mod_counter_ctrl.sv | 92 +++++++++
 tb/tb_mod_counter_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the ED13 modulo-N counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/mod_n_core.sv
// Generalised mod-N counter datapath: counts 0..term and wraps, with clear
// taking priority over enable.
module mod_n_core #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] q,
  output logic             at_term
);

  assign at_term = (q == term);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= at_term ? '0 : q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod_counter_ctrl.sv
// Sequencing controller for the programmable divide-by-N counter: config
// handshake, start/hold/stop FSM and terminal-count strobe.
module mod_counter_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH        = 3,
  parameter int unsigned DEFAULT_TERM = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_term,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             hold,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  ctrl_state_t      state, state_nxt;
  logic [WIDTH-1:0] term;
  logic             oneshot;
  logic             at_term;
  logic             cnt_en;
  logic             cnt_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      term    <= WIDTH'(DEFAULT_TERM);
      oneshot <= MODE_PERIODIC;
    end else if (cfg_valid && cfg_ready) begin
      term    <= cfg_term;
      oneshot <= cfg_oneshot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (stop)                                      state_nxt = IDLE;
        else if (hold)                                 state_nxt = HOLD;
        else if (at_term && oneshot == MODE_ONESHOT)   state_nxt = DONE;
      end
      HOLD: begin
        if (stop)       state_nxt = IDLE;
        else if (!hold) state_nxt = RUN;
      end
      DONE: begin
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clearing in IDLE/DONE keeps q at 0 there and gives every new run a q=0 first cycle.
  always_comb begin
    cfg_ready = (state == IDLE);
    busy      = (state == RUN) || (state == HOLD);
    done      = (state == DONE);
    cnt_en    = (state == RUN) && !hold;
    cnt_clr   = (state == IDLE) || (state == DONE) || stop;
    tc        = (state == RUN) && !hold && at_term;
  end

  mod_n_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .term    (term),
    .q       (q),
    .at_term (at_term)
  );

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed bench for mod_counter_ctrl with hand-computed expected sequences.
module tb_mod_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_term;
  logic       cfg_oneshot;
  logic       start;
  logic       hold;
  logic       stop;
  logic [2:0] q;
  logic       tc;
  logic       busy;
  logic       done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  mod_counter_ctrl #(
    .WIDTH        (3),
    .DEFAULT_TERM (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_term    (cfg_term),
    .cfg_oneshot (cfg_oneshot),
    .start       (start),
    .hold        (hold),
    .stop        (stop),
    .q           (q),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int unsigned eq, input logic etc,
                     input logic ebusy, input logic edone, input logic erdy);
    #1;
    check({tag, ".q"},         32'(q),         eq);
    check({tag, ".tc"},        32'(tc),        32'(etc));
    check({tag, ".busy"},      32'(busy),      32'(ebusy));
    check({tag, ".done"},      32'(done),      32'(edone));
    check({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(erdy));
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic cfg_start(input logic [2:0] t, input logic os);
    cfg_valid   = 1'b1;
    cfg_term    = t;
    cfg_oneshot = os;
    start       = 1'b1;
    tick();
    cfg_valid   = 1'b0;
    start       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; cfg_valid = 1'b0; cfg_term = '0; cfg_oneshot = 1'b0;
    start = 1'b0; hold = 1'b0; stop = 1'b0;
    #12;
    chk("rst", 0, 0, 0, 0, 1);
    reset = 1'b1;

    // default config: mod-6 periodic, then stop on the terminal cycle
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      chk("def", i % 6, (i % 6) == 5, 1, 0, 0);
      tick();
    end
    stop = 1'b1;
    chk("stop_tc", 5, 1, 1, 0, 0);
    tick(); stop = 1'b0;
    chk("stop_tc_idle", 0, 0, 0, 0, 1);

    // oneshot term=2, run twice
    cfg_valid = 1'b1; cfg_term = 3'd2; cfg_oneshot = 1'b1;
    tick(); cfg_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk("os", i, i == 2, 1, 0, 0);
        tick();
      end
      chk("os_done", 0, 0, 0, 1, 0);
    end
    do_stop();
    chk("os_idle", 0, 0, 0, 0, 1);

    // hold at q=3 for two cycles
    cfg_start(3'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("pre_hold", i, 0, 1, 0, 0);
      tick();
    end
    hold = 1'b1;
    chk("hold0", 3, 0, 1, 0, 0); tick();
    chk("hold1", 3, 0, 1, 0, 0); tick();
    hold = 1'b0;
    chk("hold2", 3, 0, 1, 0, 0); tick();
    chk("resume", 3, 0, 1, 0, 0); tick();
    chk("post4", 4, 0, 1, 0, 0); tick();
    chk("post5", 5, 1, 1, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      chk("post", i, 0, 1, 0, 0);
      tick();
    end
    chk("stop_q4", 4, 0, 1, 0, 0);
    do_stop();
    chk("stop_q4_idle", 0, 0, 0, 0, 1);

    // config offered during RUN is ignored
    start = 1'b1; tick(); start = 1'b0;
    tick();
    cfg_valid = 1'b1; cfg_term = 3'd1; cfg_oneshot = 1'b0;
    chk("cfg_run", 1, 0, 1, 0, 0);
    tick(); cfg_valid = 1'b0;
    for (int i = 2; i < 6; i++) begin
      chk("cfg_ign", i, i == 5, 1, 0, 0);
      tick();
    end
    chk("cfg_ign_wrap", 0, 0, 1, 0, 0);
    do_stop();

    // config accepted with start: mod-2
    cfg_start(3'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("mod2", i % 2, (i % 2) == 1, 1, 0, 0);
      tick();
    end
    do_stop();

    // asynchronous reset mid-run restores default term
    cfg_start(3'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("pre_rst", i, 0, 1, 0, 0);
      tick();
    end
    #2 reset = 1'b0;
    chk("async_rst", 0, 0, 0, 0, 1);
    #3 reset = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("post_rst", i % 6, (i % 6) == 5, 1, 0, 0);
      tick();
    end
    do_stop();

    // term=0 periodic and oneshot
    cfg_start(3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t0_per", 0, 1, 1, 0, 0);
      tick();
    end
    do_stop();
    cfg_start(3'd0, 1'b1);
    chk("t0_os", 0, 1, 1, 0, 0); tick();
    chk("t0_os_done", 0, 0, 0, 1, 0);
    do_stop();

    // term = all ones wraps with natural overflow
    cfg_start(3'd7, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk("t7", i % 8, (i % 8) == 7, 1, 0, 0);
      tick();
    end
    do_stop();
    chk("final_idle", 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
